// File: rtl/vgachargen_pkg.sv
// Shared map geometry, control codes and types for the character generator.
// Text-writer additions: FSM state encoding, console control codes, attribute layout.
package vgachargen_pkg;

    localparam int CH_MAP_ADDR_WIDTH  = 12;
    localparam int CH_MAP_DATA_WIDTH  = 8;
    localparam int COL_MAP_ADDR_WIDTH = 12;

    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_FF = 8'h0C;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCROLL_RD,
        SCROLL_WAIT,
        SCROLL_WR,
        CLEAR_ROW,
        CLEAR_ALL
    } text_writer_state_e;

    typedef struct packed {
        logic [3:0] fg;
        logic [3:0] bg;
    } text_attr_t;

endpackage

// File: rtl/vga_text_writer_text_cursor.sv
// Cursor row/col plus a running linear cell address (row*COLS+col) kept without a multiplier.
// Commands take effect on the next clock edge; the row saturates on the last row (scroll is the caller's job).
module text_cursor #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int LIN_W = 12,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             advance_i,
    input  logic             newline_i,
    input  logic             cr_i,
    input  logic             bs_i,
    input  logic             home_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic [LIN_W-1:0] lin_o,
    output logic             last_row_o,
    output logic             last_cell_o
);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [LIN_W-1:0] LIN_COLS     = LIN_W'(COLS);
    localparam logic [LIN_W-1:0] LIN_LAST_ROW = LIN_W'((ROWS - 1) * COLS);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [LIN_W-1:0] lin_q, lin_d;

    assign last_row_o  = (row_q == ROW_LAST);
    assign last_cell_o = last_row_o && (col_q == COL_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        lin_d = lin_q;
        if (home_i) begin
            col_d = '0;
            row_d = '0;
            lin_d = '0;
        end else if (advance_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (last_row_o) begin
                    lin_d = LIN_LAST_ROW;
                end else begin
                    row_d = row_q + 1'b1;
                    lin_d = lin_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
                lin_d = lin_q + 1'b1;
            end
        end else if (newline_i) begin
            col_d = '0;
            if (last_row_o) begin
                lin_d = LIN_LAST_ROW;
            end else begin
                row_d = row_q + 1'b1;
                lin_d = lin_q - LIN_W'(col_q) + LIN_COLS;
            end
        end else if (cr_i) begin
            col_d = '0;
            lin_d = lin_q - LIN_W'(col_q);
        end else if (bs_i && (col_q != '0)) begin
            col_d = col_q - 1'b1;
            lin_d = lin_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            col_q <= '0;
            row_q <= '0;
            lin_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            lin_q <= lin_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;
    assign lin_o = lin_q;

endmodule

// File: rtl/vga_text_writer.sv
// Console byte stream -> ch_map/col_map writer with cursor, CR/LF/BS/FF handling and row-copy scrolling.
// Printable byte: 2 cycles; scroll 3*COLS*(ROWS-1)+COLS cycles; ready drops whenever the FSM is not IDLE.
module vga_text_writer
    import vgachargen_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_arstn_i,
    input  logic                          char_valid_i,
    input  logic [7:0]                    char_data_i,
    input  logic [7:0]                    char_attr_i,
    output logic                          char_ready_o,
    output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
    output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
    output logic                          ch_map_wen_o,
    input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_rdata_i,
    output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
    output logic [7:0]                    col_map_data_o,
    output logic                          col_map_wen_o,
    input  logic [7:0]                    col_map_rdata_i,
    output logic [$clog2(COLS)-1:0]       cursor_col_o,
    output logic [$clog2(ROWS)-1:0]       cursor_row_o,
    output logic                          busy_o
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int LIN_W = CH_MAP_ADDR_WIDTH;

    localparam logic [LIN_W-1:0] LIN_COLS     = LIN_W'(COLS);
    localparam logic [LIN_W-1:0] LIN_LAST_ROW = LIN_W'((ROWS - 1) * COLS);
    localparam logic [LIN_W-1:0] LIN_END      = LIN_W'(COLS * ROWS - 1);

    text_writer_state_e               state_q, state_d;
    logic [7:0]                       byte_q, byte_d;
    text_attr_t                       attr_q, attr_d;
    logic [LIN_W-1:0]                 src_q, src_d;
    logic [CH_MAP_DATA_WIDTH-1:0]     cap_ch_q, cap_ch_d;
    logic [7:0]                       cap_col_q, cap_col_d;

    logic             cur_adv, cur_nl, cur_cr, cur_bs, cur_home;
    logic [LIN_W-1:0] cur_lin;
    logic             cur_last_row, cur_last_cell;

    logic [LIN_W-1:0]             map_addr;
    logic [CH_MAP_DATA_WIDTH-1:0] map_ch;
    logic [7:0]                   map_col;
    logic                         map_wen;

    text_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .LIN_W (LIN_W),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk_i       (sys_clk_i),
        .arstn_i     (sys_arstn_i),
        .advance_i   (cur_adv),
        .newline_i   (cur_nl),
        .cr_i        (cur_cr),
        .bs_i        (cur_bs),
        .home_i      (cur_home),
        .col_o       (cursor_col_o),
        .row_o       (cursor_row_o),
        .lin_o       (cur_lin),
        .last_row_o  (cur_last_row),
        .last_cell_o (cur_last_cell)
    );

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        attr_d    = attr_q;
        src_d     = src_q;
        cap_ch_d  = cap_ch_q;
        cap_col_d = cap_col_q;
        cur_adv   = 1'b0;
        cur_nl    = 1'b0;
        cur_cr    = 1'b0;
        cur_bs    = 1'b0;
        cur_home  = 1'b0;
        case (state_q)
            IDLE: begin
                if (char_valid_i) begin
                    attr_d = text_attr_t'(char_attr_i);
                    case (char_data_i)
                        CHAR_CR: cur_cr = 1'b1;
                        CHAR_BS: cur_bs = 1'b1;
                        CHAR_LF: begin
                            cur_nl = 1'b1;
                            if (cur_last_row) begin
                                state_d = SCROLL_RD;
                                src_d   = LIN_COLS;
                            end
                        end
                        CHAR_FF: begin
                            state_d = CLEAR_ALL;
                            src_d   = '0;
                        end
                        default: begin
                            byte_d  = char_data_i;
                            state_d = PUT;
                        end
                    endcase
                end
            end
            PUT: begin
                cur_adv = 1'b1;
                if (cur_last_cell) begin
                    state_d = SCROLL_RD;
                    src_d   = LIN_COLS;
                end else begin
                    state_d = IDLE;
                end
            end
            SCROLL_RD: state_d = SCROLL_WAIT;
            SCROLL_WAIT: begin
                cap_ch_d  = ch_map_rdata_i;
                cap_col_d = col_map_rdata_i;
                state_d   = SCROLL_WR;
            end
            SCROLL_WR: begin
                if (src_q == LIN_END) begin
                    src_d   = LIN_LAST_ROW;
                    state_d = CLEAR_ROW;
                end else begin
                    src_d   = src_q + 1'b1;
                    state_d = SCROLL_RD;
                end
            end
            // The cursor was already parked at (ROWS-1, 0) when the scroll started.
            CLEAR_ROW, CLEAR_ALL: begin
                if (src_q == LIN_END) begin
                    cur_home = (state_q == CLEAR_ALL);
                    state_d  = IDLE;
                end else begin
                    src_d = src_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        map_addr = '0;
        map_ch   = '0;
        map_col  = '0;
        map_wen  = 1'b0;
        case (state_q)
            PUT: begin
                map_addr = cur_lin;
                map_ch   = CH_MAP_DATA_WIDTH'(byte_q);
                map_col  = attr_q;
                map_wen  = 1'b1;
            end
            SCROLL_RD, SCROLL_WAIT: map_addr = src_q;
            SCROLL_WR: begin
                map_addr = src_q - LIN_COLS;
                map_ch   = cap_ch_q;
                map_col  = cap_col_q;
                map_wen  = 1'b1;
            end
            CLEAR_ROW, CLEAR_ALL: begin
                map_addr = src_q;
                map_ch   = CH_MAP_DATA_WIDTH'(BLANK_CHAR);
                map_col  = attr_q;
                map_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_arstn_i) begin
        if (!sys_arstn_i) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            attr_q    <= '0;
            src_q     <= '0;
            cap_ch_q  <= '0;
            cap_col_q <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            attr_q    <= attr_d;
            src_q     <= src_d;
            cap_ch_q  <= cap_ch_d;
            cap_col_q <= cap_col_d;
        end
    end

    assign char_ready_o   = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign ch_map_addr_o  = map_addr;
    assign ch_map_data_o  = map_ch;
    assign ch_map_wen_o   = map_wen;
    assign col_map_addr_o = COL_MAP_ADDR_WIDTH'(map_addr);
    assign col_map_data_o = map_col;
    assign col_map_wen_o  = map_wen;

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer on a 4x3 screen with a 1-cycle-read map model.
module tb_vga_text_writer;

    logic clk = 1'b0;
    logic rst_n;
    logic char_valid;
    logic [7:0] char_data, char_attr;
    logic char_ready;
    logic [11:0] ch_addr, col_addr;
    logic [7:0] ch_data, col_data, ch_rdata, col_rdata;
    logic ch_wen, col_wen;
    logic [1:0] cur_col, cur_row;
    logic busy;

    always #5 clk = ~clk;

    vga_text_writer #(.COLS(4), .ROWS(3), .BLANK_CHAR(8'h20)) dut (
        .sys_clk_i       (clk),
        .sys_arstn_i     (rst_n),
        .char_valid_i    (char_valid),
        .char_data_i     (char_data),
        .char_attr_i     (char_attr),
        .char_ready_o    (char_ready),
        .ch_map_addr_o   (ch_addr),
        .ch_map_data_o   (ch_data),
        .ch_map_wen_o    (ch_wen),
        .ch_map_rdata_i  (ch_rdata),
        .col_map_addr_o  (col_addr),
        .col_map_data_o  (col_data),
        .col_map_wen_o   (col_wen),
        .col_map_rdata_i (col_rdata),
        .cursor_col_o    (cur_col),
        .cursor_row_o    (cur_row),
        .busy_o          (busy)
    );

    logic [7:0] mem_ch [16];
    logic [7:0] mem_col [16];
    always @(posedge clk) begin
        if (ch_wen) mem_ch[ch_addr[3:0]] <= ch_data;
        if (col_wen) mem_col[col_addr[3:0]] <= col_data;
        ch_rdata  <= mem_ch[ch_addr[3:0]];
        col_rdata <= mem_col[col_addr[3:0]];
    end

    typedef struct {
        logic [11:0] a;
        logic [7:0]  c;
        logic [7:0]  k;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    logic [7:0] ref_ch [12];
    logic [7:0] ref_col [12];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every map write the DUT presents is matched against the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (ch_wen !== 1'b0 || col_wen !== 1'b0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%0d ch=%02h col=%02h, no write expected",
                         ch_addr, ch_data, col_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (ch_wen !== 1'b1 || col_wen !== 1'b1 || ch_addr !== mon_e.a || col_addr !== mon_e.a
                    || ch_data !== mon_e.c || col_data !== mon_e.k) begin
                    errors++;
                    $display("FAIL write: got wen=%b/%b addr=%0d/%0d ch=%02h col=%02h, expected addr=%0d ch=%02h col=%02h",
                             ch_wen, col_wen, ch_addr, col_addr, ch_data, col_data, mon_e.a, mon_e.c, mon_e.k);
                end
            end
        end
    end

    function automatic void push(input int a, input logic [7:0] c, input logic [7:0] k, input bit upd);
        wr_t e;
        e.a = 12'(a);
        e.c = c;
        e.k = k;
        exp_q.push_back(e);
        if (upd) begin
            ref_ch[a]  = c;
            ref_col[a] = k;
        end
    endfunction

    function automatic void push_scroll(input logic [7:0] attr);
        for (int s = 4; s < 12; s++) push(s - 4, ref_ch[s], ref_col[s], 1'b1);
        for (int a = 8; a < 12; a++) push(a, 8'h20, attr, 1'b1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cur(input int r, input int c);
        chk("cursor_row", 32'(cur_row), 32'(r));
        chk("cursor_col", 32'(cur_col), 32'(c));
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_ready"}, 32'(char_ready), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_wen"}, {30'd0, ch_wen, col_wen}, 32'd0);
        chk({nm, "_addr"}, {8'd0, ch_addr, col_addr}, 32'd0);
        chk({nm, "_data"}, {16'd0, ch_data, col_data}, 32'd0);
        chk_cur(0, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        bit ok = 1'b0;
        char_valid = 1'b1;
        char_data  = d;
        char_attr  = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (char_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready stayed low for byte %02h, expected it to rise", d);
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc    = cyc;
            char_valid = 1'b0;
        end
    endtask

    task automatic count_busy(output int n);
        bit done = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles, expected it to fall", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_quiet("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int prev;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int prev;
        bit seen;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_attr  = 8'h00;
        for (int i = 0; i < 12; i++) begin
            ref_ch[i]  = 8'h00;
            ref_col[i] = 8'h00;
        end
        #3 chk_quiet("por");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single printable byte: written one cycle after accept, ready low for exactly one cycle.
        push(0, 8'h41, 8'h1F, 1'b1);
        send(8'h41, 8'h1F);
        @(negedge clk);
        chk("put_ready_low", 32'(char_ready), 32'd0);
        chk("put_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("put_ready_back", 32'(char_ready), 32'd1);
        chk_cur(0, 1);
        @(posedge clk);
        #1;

        // Back-to-back bytes: one accept every two cycles, addresses 0..4.
        do_reset();
        for (int i = 0; i < 5; i++) push(i, 8'h61 + 8'(i), 8'h2E, 1'b1);
        send(8'h61, 8'h2E);
        prev = acc_cyc;
        for (int i = 1; i < 5; i++) begin
            send(8'h61 + 8'(i), 8'h2E);
            chk("accept_spacing", 32'(acc_cyc - prev), 32'd2);
            prev = acc_cyc;
        end
        wait_idle();
        chk_cur(1, 1);

        // Fill the screen, last-cell wrap scrolls, then one more byte on the fresh row.
        do_reset();
        for (int i = 0; i < 12; i++) push(i, 8'h30 + 8'(i), 8'h5A, 1'b1);
        push_scroll(8'h5A);
        for (int i = 0; i < 12; i++) send(8'h30 + 8'(i), 8'h5A);
        @(negedge clk);
        chk("last_put_wen", 32'(ch_wen), 32'd1);
        count_busy(n);
        chk("scroll_busy_after_put", 32'(n), 32'd28);
        chk_cur(2, 0);
        push(8, 8'h3C, 8'h5A, 1'b1);
        send(8'h3C, 8'h5A);
        wait_idle();
        chk_cur(2, 1);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] e;
            e = (i < 8) ? 8'h34 + 8'(i) : ((i == 8) ? 8'h3C : 8'h20);
            chk("map_after_scroll", 32'(mem_ch[i]), 32'(e));
        end

        // BS at home is a no-op; CR returns to column 0 without writing.
        do_reset();
        send(8'h08, 8'h00);
        wait_idle();
        chk_cur(0, 0);
        for (int i = 0; i < 7; i++) push(i, 8'h40 + 8'(i), 8'h3C, 1'b1);
        for (int i = 0; i < 7; i++) send(8'h40 + 8'(i), 8'h3C);
        wait_idle();
        chk_cur(1, 3);
        send(8'h0D, 8'h00);
        wait_idle();
        chk_cur(1, 0);
        send(8'h08, 8'h00);
        wait_idle();
        chk_cur(1, 0);

        // LF moves down; LF on the last row scrolls and clears with the LF's attribute.
        send(8'h0A, 8'h00);
        wait_idle();
        chk_cur(2, 0);
        push(8, 8'h5A, 8'h4B, 1'b1);
        send(8'h5A, 8'h4B);
        wait_idle();
        chk_cur(2, 1);
        push_scroll(8'h0F);
        send(8'h0A, 8'h0F);
        count_busy(n);
        chk("scroll_busy_after_lf", 32'(n), 32'd28);
        chk_cur(2, 0);
        chk("lf_clear_attr", 32'(mem_col[11]), 32'h0F);

        // Form feed clears all twelve cells and homes the cursor.
        for (int i = 0; i < 12; i++) push(i, 8'h20, 8'h70, 1'b1);
        send(8'h0C, 8'h70);
        count_busy(n);
        chk("clear_all_busy", 32'(n), 32'd12);
        chk_cur(0, 0);
        chk("ff_cell0", {16'd0, mem_ch[0], mem_col[0]}, 32'h2070);
        chk("ff_cell11", {16'd0, mem_ch[11], mem_col[11]}, 32'h2070);

        // Reset landing in the first SCROLL_WR cycle aborts at once.
        do_reset();
        send(8'h0A, 8'h00);
        wait_idle();
        send(8'h0A, 8'h00);
        wait_idle();
        chk_cur(2, 0);
        push(0, ref_ch[4], ref_col[4], 1'b0);
        send(8'h0A, 8'h33);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ch_wen === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("scroll_wr_reached", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_quiet("abort");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(0, 8'h55, 8'h11, 1'b1);
        send(8'h55, 8'h11);
        wait_idle();
        chk_cur(0, 1);

        repeat (3) @(negedge clk);
        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
